// File: rtl/hilo_muldiv_unit_if.sv
// Decode-side command/result bundle for hilo_muldiv_unit.
// master = decode/issue side, slave = the HI/LO sequencer.
interface hilo_muldiv_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic        rd_hilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;
    logic        div_zero;

    modport master (
        output start, op, x, y, rd_hilo,
        input  hi, lo, busy, done, stall, div_zero
    );

    modport slave (
        input  start, op, x, y, rd_hilo,
        output hi, lo, busy, done, stall, div_zero
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Iterative 32x32 shift-add multiply / restoring divide owning the HI/LO pair.
// Optional MULDIV_DIVZERO_TRAP_EN: divide by zero flags div_zero instead of the legacy LO=x, HI=0.
module hilo_muldiv_unit (
    input  logic              clk,
    input  logic              rst,
    hilo_muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state, state_next;
    logic [5:0]  cnt;
    logic [63:0] acc;       // mul: {partial product, multiplier}; div: {remainder, dividend->quotient}
    logic [31:0] opnd;      // multiplicand or divisor magnitude
    logic        is_div;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;

    logic        cmd_muldiv, cmd_dz, cmd_mthi, cmd_mtlo, accept;
    logic [31:0] x_mag, y_mag;
    logic [32:0] mul_sum, div_shift, div_diff;
    logic [63:0] acc_step, prod_fix;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        cmd_muldiv = bus.start && !bus.op[2];
        cmd_dz     = cmd_muldiv && bus.op[1] && (bus.y == '0);
        cmd_mthi   = bus.start && (bus.op == 3'd4);
        cmd_mtlo   = bus.start && (bus.op == 3'd5);
        x_mag      = (bus.op[0] && bus.x[31]) ? -bus.x : bus.x;
        y_mag      = (bus.op[0] && bus.y[31]) ? -bus.y : bus.y;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_muldiv && !cmd_dz) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC:    if (cnt == 6'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A trial subtraction that stays non-negative sets the quotient bit; bit 32 of the
    // 33-bit difference is its sign since the shifted remainder is always < 2*divisor.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        div_shift = {acc[63:32], acc[31]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!is_div)
            acc_step = {mul_sum, acc[31:1]};
        else if (!div_diff[32])
            acc_step = {div_diff[31:0], acc[30:0], 1'b1};
        else
            acc_step = {div_shift[31:0], acc[30:0], 1'b0};
        prod_fix = neg_q ? -acc : acc;
        quo_fix  = neg_q ? -acc[31:0] : acc[31:0];
        rem_fix  = neg_r ? -acc[63:32] : acc[63:32];
    end

`ifdef MULDIV_DIVZERO_TRAP_EN
    logic dz_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef MULDIV_DIVZERO_TRAP_EN
            dz_q   <= 1'b0;
`endif
        end else begin
            state  <= state_next;
            busy_q <= (state_next != IDLE);
            done_q <= (state_next == FIX);
`ifdef MULDIV_DIVZERO_TRAP_EN
            dz_q   <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        is_div <= bus.op[1];
                        acc    <= {32'd0, bus.op[1] ? x_mag : y_mag};
                        opnd   <= bus.op[1] ? y_mag : x_mag;
                        neg_q  <= bus.op[0] & (bus.x[31] ^ bus.y[31]);
                        neg_r  <= bus.op[0] & bus.x[31];
                    end else if (cmd_dz) begin
`ifdef MULDIV_DIVZERO_TRAP_EN
                        dz_q   <= 1'b1;
`else
                        hi_q   <= '0;
                        lo_q   <= bus.x;
                        done_q <= 1'b1;
`endif
                    end else if (cmd_mthi) begin
                        hi_q <= bus.x;
                    end else if (cmd_mtlo) begin
                        lo_q <= bus.x;
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt + 6'd1;
                end
                FIX: begin
                    if (is_div) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.stall = busy_q & (bus.rd_hilo | bus.start);
`ifdef MULDIV_DIVZERO_TRAP_EN
    assign bus.div_zero = dz_q;
`else
    assign bus.div_zero = 1'b0;
`endif
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit: directed vector table, corner sequences,
// and random commands compared against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    hilo_muldiv_unit_if bus ();

    hilo_muldiv_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // Reference: HI/LO from the instruction definitions using 64-bit integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = hi_m;
        el = lo_m;
        case (op)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; eh = p[63:32]; el = p[31:0]; end
            3'd1: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
            3'd2: begin eh = a % b; el = a / b; end
            3'd3: begin q = sa / sb; r = sa % sb; eh = r[31:0]; el = q[31:0]; end
            3'd4: eh = a;
            3'd5: el = a;
            default: ;
        endcase
    endfunction

    task automatic do_muldiv(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] eh, input logic [31:0] el, input string name);
        int n;
        bus.start = 1'b1;
        bus.op    = op;
        bus.x     = a;
        bus.y     = b;
        tick();
        bus.start = 1'b0;
        check({name, "_busy_n1"}, bus.busy, 1'b1);
        n = 1;
        while (!bus.done && n < 60) begin
            tick();
            n++;
        end
        check({name, "_done_cycle"}, n, 33);
        check({name, "_busy_at_done"}, bus.busy, 1'b1);
        tick();
        check({name, "_hi"}, bus.hi, eh);
        check({name, "_lo"}, bus.lo, el);
        check({name, "_busy_after"}, bus.busy, 1'b0);
        hi_m = eh;
        lo_m = el;
    endtask

    task automatic do_mt(input logic [2:0] op, input logic [31:0] a, input string name);
        bus.start = 1'b1;
        bus.op    = op;
        bus.x     = a;
        tick();
        bus.start = 1'b0;
        if (op == 3'd4) hi_m = a; else lo_m = a;
        check({name, "_hi"}, bus.hi, hi_m);
        check({name, "_lo"}, bus.lo, lo_m);
        check({name, "_busy"}, bus.busy, 1'b0);
        check({name, "_done"}, bus.done, 1'b0);
    endtask

    task automatic do_divzero(input logic [2:0] op, input logic [31:0] a, input string name);
        bus.start = 1'b1;
        bus.op    = op;
        bus.x     = a;
        bus.y     = '0;
        tick();
        bus.start = 1'b0;
        check({name, "_busy"}, bus.busy, 1'b0);
`ifdef MULDIV_DIVZERO_TRAP_EN
        check({name, "_div_zero"}, bus.div_zero, 1'b1);
        check({name, "_done"}, bus.done, 1'b0);
        check({name, "_hi"}, bus.hi, hi_m);
        check({name, "_lo"}, bus.lo, lo_m);
        tick();
        check({name, "_div_zero_pulse"}, bus.div_zero, 1'b0);
`else
        hi_m = '0;
        lo_m = a;
        check({name, "_done"}, bus.done, 1'b1);
        check({name, "_div_zero"}, bus.div_zero, 1'b0);
        check({name, "_hi"}, bus.hi, hi_m);
        check({name, "_lo"}, bus.lo, lo_m);
        tick();
        check({name, "_done_pulse"}, bus.done, 1'b0);
`endif
        check({name, "_busy_next"}, bus.busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] eh, el, a, b;
        logic [2:0]  op;
        logic        seen_done;
        logic [31:0] corner [5];
        int          n;

        corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;

        vecs[0]  = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
        vecs[1]  = '{3'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_m3x7"};
        vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7d2"};
        vecs[3]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_wrap"};
        vecs[4]  = '{3'd0, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, "multu_3x5"};
        vecs[5]  = '{3'd2, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, "divu_100d7"};
        vecs[6]  = '{3'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, "divu_max_d1"};
        vecs[7]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div_7dm2"};
        vecs[8]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_min_sq"};
        vecs[9]  = '{3'd1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000, "mult_min_x1"};
        vecs[10] = '{3'd2, 32'h00000005, 32'h0000000A, 32'h00000005, 32'h00000000, "divu_5d10"};

        bus.start = 1'b0; bus.op = '0; bus.x = '0; bus.y = '0; bus.rd_hilo = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_div_zero", bus.div_zero, 1'b0);
        check("rst_stall", bus.stall, 1'b0);
        rst = 1'b0;

        // MTHI / MTLO on consecutive edges
        do_mt(3'd4, 32'hAAAA5555, "mthi");
        bus.start = 1'b1;
        do_mt(3'd5, 32'h5555AAAA, "mtlo");

        for (int i = 0; i < NV; i++)
            do_muldiv(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name);

        do_divzero(3'd2, 32'd100, "divu_by0");
        do_divzero(3'd3, 32'hFFFFFFFB, "div_by0");

        // idle: rd_hilo alone must not stall
        bus.rd_hilo = 1'b1;
        #1;
        check("stall_idle", bus.stall, 1'b0);
        bus.rd_hilo = 1'b0;

        // start + rd_hilo during CALC: stalls, MTLO ignored
        bus.start = 1'b1; bus.op = 3'd0; bus.x = 32'h0000ABCD; bus.y = 32'h00001000;
        tick();
        tick(); tick(); tick();
        bus.op = 3'd5; bus.x = 32'h00001234; bus.rd_hilo = 1'b1;
        #1;
        check("stall_calc", bus.stall, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        check("stall_held", bus.stall, 1'b1);
        check("busy_held", bus.busy, 1'b1);
        bus.start = 1'b0;
        #1;
        check("stall_rd_only", bus.stall, 1'b1);
        bus.rd_hilo = 1'b0;
        #1;
        check("stall_none", bus.stall, 1'b0);
        n = 0;
        while (!bus.done && n < 60) begin tick(); n++; end
        check("stall_seq_done_seen", bus.done, 1'b1);
        tick();
        check("stall_seq_lo", bus.lo, 32'h0ABCD000);
        check("stall_seq_hi", bus.hi, 32'h00000000);

        // reset at CALC step 10 discards the operation
        bus.start = 1'b1; bus.op = 3'd0; bus.x = 32'h12345678; bus.y = 32'h00000009;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        hi_m = '0;
        lo_m = '0;
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_hi", bus.hi, 32'd0);
        check("midrst_lo", bus.lo, 32'd0);
        seen_done = bus.done;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen_done = seen_done | bus.done | bus.busy;
        end
        check("midrst_no_done", seen_done, 1'b0);
        do_muldiv(3'd0, 32'd3, 32'd5, 32'd0, 32'd15, "post_rst_multu");

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            if (op >= 3'd4) begin
                do_mt(op, a, "rnd_mt");
            end else if (op[1] && b == '0) begin
                do_divzero(op, a, "rnd_by0");
            end else begin
                model(op, a, b, eh, el);
                do_muldiv(op, a, b, eh, el, "rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
